// File: rtl/mult_div_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with the HI/LO register pair.
// Each RUN cycle performs one shift-add or restoring shift-subtract step. FIX applies the signs and writes HI/LO.
module mult_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div_q, neg_q, rem_neg_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               accept;
  logic               sgn_1, sgn_2;
  logic [WIDTH-1:0]   abs_1, abs_2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept = (state_q == IDLE) && start && !busy_q;

  // The magnitude of the most negative value wraps to itself, and the step logic reads it as unsigned.
  always_comb begin
    sgn_1 = op[0] & input_1[WIDTH-1];
    sgn_2 = op[0] & input_2[WIDTH-1];
    abs_1 = sgn_1 ? -input_1 : input_1;
    abs_2 = sgn_2 ? -input_2 : input_2;
  end

  // Multiply keeps {partial, multiplier} in acc_q. Divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge  = div_sh >= {1'b0, opnd_q};
    div_rem = div_ge ? (div_sh[WIDTH-1:0] - opnd_q) : div_sh[WIDTH-1:0];
    acc_d   = is_div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                       : {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // busy_q lags the state by one edge, so it rises the cycle after a start and falls the cycle after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_q != IDLE);
      if (!busy_q) begin
        if (mthi) hi_q <= wdata;
        if (mtlo) lo_q <= wdata;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op[1] && (input_2 == '0)) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              cnt_q   <= '0;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; the control FSM loads them before reading them.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_q  <= op[1];
      neg_q     <= sgn_1 ^ sgn_2;
      rem_neg_q <= sgn_1;
      opnd_q    <= op[1] ? abs_2 : abs_1;
      acc_q     <= {{WIDTH{1'b0}}, (op[1] ? abs_1 : abs_2)};
    end else if (state_q == RUN) begin
      acc_q <= acc_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl. Expected results are hand-computed 32-bit MIPS MULT/DIV values.
module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] input_1, input_2, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt, done_cnt, done_at;

  localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11;

  mult_div_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .input_1(input_1), .input_2(input_2),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples are taken on the falling edge, so i counts rising edges after the start edge.
  // When inj_at >= 0, a second start and an mtlo are driven in that cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, output int b_cnt, output int d_cnt, output int d_at);
    @(negedge clk);
    start = 1'b1; op = o; input_1 = a; input_2 = b;
    b_cnt = 0; d_cnt = 0; d_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      mtlo  = 1'b0;
      if (i == inj_at) begin
        start = 1'b1; op = OP_MULTU; input_1 = 32'h2; input_2 = 32'h3;
        mtlo = 1'b1; wdata = 32'hDEADBEEF;
      end
      if (busy) b_cnt++;
      if (done) begin d_cnt++; d_at = i; end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; input_1 = '0; input_2 = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_hi",   64'(hi),   64'h0);
    check("rst_lo",   64'(lo),   64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    reset = 1'b0;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, busy_cnt, done_cnt, done_at);
    check("multu_busy_cycles", 64'(busy_cnt), 64'd33);
    check("multu_done_count",  64'(done_cnt), 64'd1);
    check("multu_done_at",     64'(done_at),  64'd33);
    check("multu_hi", 64'(hi), 64'hFFFFFFFE);
    check("multu_lo", 64'(lo), 64'h00000001);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, -1, busy_cnt, done_cnt, done_at);
    check("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

    run_op(OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, -1, busy_cnt, done_cnt, done_at);
    check("mult_negneg_hi", 64'(hi), 64'h0);
    check("mult_negneg_lo", 64'(lo), 64'd30);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, busy_cnt, done_cnt, done_at);
    check("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, -1, busy_cnt, done_cnt, done_at);
    check("div_negdiv_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_negdiv_hi", 64'(hi), 64'd1);

    run_op(OP_DIVU, 32'd100, 32'd7, -1, busy_cnt, done_cnt, done_at);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);
    check("divu_done_at", 64'(done_at), 64'd33);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, busy_cnt, done_cnt, done_at);
    check("div_ovf_lo", 64'(lo), 64'h80000000);
    check("div_ovf_hi", 64'(hi), 64'h0);

    // Preset HI/LO, then divide by zero: done pulses immediately and HI/LO must hold.
    @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk); mtlo = 1'b0;
    check("mthi_write", 64'(hi), 64'h1234);
    check("mtlo_write", 64'(lo), 64'h5678);
    run_op(OP_DIV, 32'd5, 32'd0, -1, busy_cnt, done_cnt, done_at);
    check("div0_busy_cycles", 64'(busy_cnt), 64'd0);
    check("div0_done_count",  64'(done_cnt), 64'd1);
    check("div0_done_at",     64'(done_at),  64'd0);
    check("div0_hi", 64'(hi), 64'h1234);
    check("div0_lo", 64'(lo), 64'h5678);

    // A second start and an mtlo that arrive mid-operation must both be dropped.
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, busy_cnt, done_cnt, done_at);
    check("inj_busy_cycles", 64'(busy_cnt), 64'd33);
    check("inj_done_count",  64'(done_cnt), 64'd1);
    check("inj_hi", 64'(hi), 64'hFFFFFFFE);
    check("inj_lo", 64'(lo), 64'h00000001);

    // Assert reset during RUN: the operation is abandoned and HI/LO are cleared.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; input_1 = 32'hFFFF; input_2 = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstrun_busy", 64'(busy), 64'h0);
    check("rstrun_done", 64'(done), 64'h0);
    check("rstrun_hi",   64'(hi),   64'h0);
    check("rstrun_lo",   64'(lo),   64'h0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rstrun_no_done", 64'(done_cnt), 64'd0);

    run_op(OP_MULTU, 32'd3, 32'd5, -1, busy_cnt, done_cnt, done_at);
    check("post_rst_lo", 64'(lo), 64'd15);
    check("post_rst_hi", 64'(hi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Iterative multiply/divide sequencer for the MIPS core; implements MULT, MULTU, DIV, DIVU.
- Holds the HI/LO register pair and supports MTHI/MTLO writes.
- Drives one shift-add/shift-subtract step per clock over 32 cycles, with a one-cycle sign fix-up.
- Sits beside the main ALU in EX; the hazard unit stalls MFHI/MFLO and a new start while `busy` is high.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- ITER, 32, iteration cycles in RUN; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only when idle.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- input_1  input  WIDTH  rs operand; multiplicand or dividend.
- input_2  input  WIDTH  rt operand; multiplier or divisor.
- mthi  input  1  write `wdata` to HI.
- mtlo  input  1  write `wdata` to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse in the cycle HI/LO are updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE. Reset in any state aborts the operation at that edge; the partial result is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - When start=1, latch op. Latch |input_1| and |input_2| for signed ops, raw values for unsigned ops. Latch the sign flags.
  - DIVU/DIV with input_2==0: stay in IDLE, assert done for 1 cycle, leave hi/lo unchanged, keep busy=0.
  - Otherwise go to RUN with counter=0; busy=1 from the next cycle.
- RUN, one step per cycle for ITER cycles; counter increments; exit to FIX when counter==ITER-1.
  - Multiply: 2*WIDTH-bit accumulator. Add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: restoring algorithm. Shift remainder:quotient left, trial-subtract the divisor, keep it if non-negative and set the quotient bit.
- FIX, one cycle:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Write {hi,lo} = product, or hi=remainder, lo=quotient. Pulse done=1, go to IDLE; busy falls on the next edge.
- Latency: start at edge N gives busy high for ITER+1 cycles. hi/lo are valid and done is high at edge N+ITER+1; busy is low from N+ITER+2.
- start while busy: ignored; no queuing.
- mthi/mtlo:
  - Effective only when busy=0 and no operation completes in the same cycle; ignored while busy.
  - mthi and mtlo together both write `wdata`.
  - Same-cycle start and mthi/mtlo in IDLE: the mt write takes effect and the operation starts from the sampled operands.
- Overflow and absolute values:
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - |0x80000000| is treated as unsigned 0x80000000.
- hi/lo hold their values between writes; no combinational path from inputs to hi/lo/busy/done.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> busy for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT 0xFFFFFFFD (-3) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIV by 0 with hi=0x1234, lo=0x5678 preset by MTHI/MTLO -> done after 1 cycle, busy never high, hi/lo unchanged.
- Second start pulse and an mtlo while busy -> both ignored; the first result is correct; lo not overwritten by wdata.
- Reset asserted mid-RUN (cycle 10) -> next cycle busy=0, hi=lo=0, no done; a new MULTU 3*5 then gives lo=15.
